regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register data width in bits.
REQ-002 SHALL have parameter NREGS, default 16, meaning register count; a power of two, at least 4.
REQ-003 SHALL have parameter NRP, default 2, meaning number of read ports.
REQ-004 SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding when 1.
REQ-005 SHALL derive local constant AW = clog2(NREGS) as the register address width.
REQ-006 SHALL have port clk, input, 1, the single system clock.
REQ-007 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-008 SHALL have port init_done, output, 1, high once every register has been cleared.
REQ-009 SHALL have port rd_addr, input, NRP*AW, packed read addresses with port i at slice i.
REQ-010 SHALL have port rd_data, output, NRP*XLEN, packed read data.
REQ-011 SHALL have port rd_busy, output, NRP, scoreboard pending bit for each read address.
REQ-012 SHALL have ports wa_en, wa_addr and wa_data, inputs, 1/AW/XLEN, write port A.
REQ-013 SHALL have ports wb_en, wb_addr and wb_data, inputs, 1/AW/XLEN, write port B.
REQ-014 SHALL have ports iss_en and iss_addr, inputs, 1/AW, issue request that marks a destination register pending.

Function
REQ-015 SHALL have register 0 read as zero, never busy, with writes and issues to it ignored.
REQ-016 SHALL have reads that are combinational: rd_data[i] is the stored value of rd_addr[i].
REQ-017 SHALL, when BYPASS=1, forward the port B data, else the port A data, to a read whose address matches an enabled same-cycle write (address not 0).
REQ-018 SHALL, when BYPASS=0, return the pre-write stored value to such a read.
REQ-019 SHALL update storage on the rising clk edge from enabled writes.
REQ-020 SHALL store only the port B data when wa_addr equals wb_addr and both ports are enabled.
REQ-021 SHALL set the pending bit of iss_addr at the edge when iss_en is high.
REQ-022 SHALL clear the pending bit of each enabled write address at the edge.
REQ-023 SHALL leave the pending bit set when an issue and a write target the same register in one cycle (issue wins).
REQ-024 SHALL drive rd_busy[i] from the registered pending bit, masked to 0 when BYPASS=1 and a same-cycle write matches rd_addr[i].
REQ-025 SHALL implement a two-state FSM, INIT and RUN, with a counter of width AW.
REQ-026 SHALL, in INIT, write zero to register cnt each cycle and increment cnt, starting from cnt = 1.
REQ-027 SHALL move from INIT to RUN at the edge that clears register NREGS-1, so init_done rises NREGS-1 cycles after rst_n goes high.
REQ-028 SHALL, in INIT, ignore writes and issues, force rd_data to 0 and force rd_busy to 0.
REQ-029 SHALL hold the RUN state until reset.

Reset
REQ-030 SHALL, at every edge with rst_n low, set state to INIT, cnt to 1, all pending bits to 0 and init_done to 0.
REQ-031 SHALL NOT clear the storage array directly from rst_n, so the array maps to RAM or latch arrays; clearing is done by INIT.
REQ-032 SHALL restart initialisation from cnt = 1 when reset is asserted mid-INIT or in RUN.

Structure
REQ-033 SHALL place the state enum (INIT, RUN) and the AW derivation function in the shared package regfile_pkg.
REQ-034 SHALL implement the scoreboard as sub-module regfile_scoreboard (issue/clear ports, pending vector output) and keep storage, forwarding and the FSM in regfile_sb.

Verification
REQ-035 SHALL cover: fill x1..x15 with nonzero values, pulse rst_n low for 1 cycle -> init_done low for exactly 15 cycles, then all reads of x1..x15 return 0.
REQ-036 SHALL cover: in RUN, wa writes x5=0xDEADBEEF and wb writes x5=0x12345678 in the same cycle -> a read of x5 returns 0x12345678 that cycle (BYPASS=1) and every cycle afterwards.
REQ-037 SHALL cover: write x0=0xFFFFFFFF and issue x0 -> rd_data for x0 is 0 and rd_busy for x0 is 0.
REQ-038 SHALL cover: issue x7 -> rd_busy for x7 is 1 next cycle; wa writes x7=0xA5 -> busy is 0 and data 0xA5 in the same cycle, and still 0 next cycle.
REQ-039 SHALL cover: issue x3 and write x3 in the same cycle -> busy for x3 is 1 after the edge.
REQ-040 SHALL cover: with BYPASS=0, write x9=0x55 while reading x9 (old value 0x11) -> reads 0x11 that cycle and 0x55 next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the scoreboarded register file.
package regfile_pkg;

    typedef enum logic {
        StInit,
        StRun
    } state_e;

    function automatic int unsigned addr_width(input int unsigned nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: issue sets a bit, writes clear it, issue beats a same-cycle clear.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = 16,
    localparam int unsigned AW   = addr_width(NREGS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             iss_en_i,
    input  logic [AW-1:0]    iss_addr_i,
    input  logic             clr_a_en_i,
    input  logic [AW-1:0]    clr_a_addr_i,
    input  logic             clr_b_en_i,
    input  logic [AW-1:0]    clr_b_addr_i,
    output logic [NREGS-1:0] pending_o
);

    logic [NREGS-1:0] pending_d, pending_q;

    always_comb begin
        pending_d = pending_q;
        if (clr_a_en_i) pending_d[clr_a_addr_i] = 1'b0;
        if (clr_b_en_i) pending_d[clr_b_addr_i] = 1'b0;
        if (iss_en_i)   pending_d[iss_addr_i]   = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-write, NRP-read register file with x0 hardwired to zero, optional write forwarding,
// a pending-bit scoreboard and a sequential clear of the array after reset.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned NRP    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = addr_width(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_done,
    input  logic [NRP*AW-1:0] rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]    rd_busy,
    input  logic              wa_en,
    input  logic [AW-1:0]     wa_addr,
    input  logic [XLEN-1:0]   wa_data,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr
);

    localparam bit Byp = (BYPASS != 0);

    state_e            state_d, state_q;
    logic [AW-1:0]     cnt_d, cnt_q;
    logic [XLEN-1:0]   mem_q [NREGS];
    logic [NREGS-1:0]  pending;
    logic              run, we_a, we_b, iss_ok;

    assign run       = (state_q == StRun);
    assign init_done = run;
    assign we_a      = run && wa_en && (wa_addr != '0);
    assign we_b      = run && wb_en && (wb_addr != '0);
    assign iss_ok    = run && iss_en && (iss_addr != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == StInit) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(NREGS - 1)) state_d = StRun;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StInit;
            cnt_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // No reset on the array; the INIT sweep clears it. Port B issued last so it wins a tie.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            mem_q[cnt_q] <= '0;
        end else begin
            if (we_a) mem_q[wa_addr] <= wa_data;
            if (we_b) mem_q[wb_addr] <= wb_data;
        end
    end

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .iss_en_i     (iss_ok),
        .iss_addr_i   (iss_addr),
        .clr_a_en_i   (we_a),
        .clr_a_addr_i (wa_addr),
        .clr_b_en_i   (we_b),
        .clr_b_addr_i (wb_addr),
        .pending_o    (pending)
    );

    for (genvar gi = 0; gi < NRP; gi++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit_a, hit_b;

        assign addr  = rd_addr[gi*AW +: AW];
        assign hit_a = Byp && we_a && (wa_addr == addr);
        assign hit_b = Byp && we_b && (wb_addr == addr);

        assign rd_data[gi*XLEN +: XLEN] = !run            ? '0      :
                                          (addr == '0)    ? '0      :
                                          hit_b           ? wb_data :
                                          hit_a           ? wa_data :
                                                            mem_q[addr];
        assign rd_busy[gi] = run && pending[addr] && !(hit_a || hit_b);
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: two DUTs (BYPASS=1 and BYPASS=0) share stimulus; a reference model pushes
// expected read results into a queue that a negedge monitor pops and compares.
module tb_regfile_sb;

    typedef struct packed {
        logic [63:0] d1;
        logic [63:0] d0;
        logic [1:0]  b1;
        logic [1:0]  b0;
        logic        done;
        logic        cd;
        logic        cb;
        logic        sel;
        logic [31:0] dd;
        logic        db;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rd_addr;
    logic        wa_en, wb_en, iss_en;
    logic [3:0]  wa_addr, wb_addr, iss_addr;
    logic [31:0] wa_data, wb_data;
    logic [63:0] rd_data1, rd_data0;
    logic [1:0]  rd_busy1, rd_busy0;
    logic        done1, done0;

    int checks = 0;
    int failures = 0;
    exp_t q[$];

    logic [31:0] m_mem [16];
    bit          m_pend [16];
    bit          m_run = 1'b0;
    bit          m_known = 1'b0;
    int          m_icyc = 0;

    logic        dir_cd = 1'b0, dir_cb = 1'b0, dir_sel = 1'b1, dir_b = 1'b0;
    logic [31:0] dir_d = '0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(32), .NREGS(16), .NRP(2), .BYPASS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .init_done(done1), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_busy(rd_busy1), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .iss_en(iss_en),
        .iss_addr(iss_addr)
    );

    regfile_sb #(.XLEN(32), .NREGS(16), .NRP(2), .BYPASS(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .init_done(done0), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_busy(rd_busy0), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .iss_en(iss_en),
        .iss_addr(iss_addr)
    );

    function automatic bit wr_hit(input logic [3:0] a);
        return (wa_en && wa_addr == a) || (wb_en && wb_addr == a);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [3:0] a, input bit byp);
        if (!m_run || a == 4'd0) return 32'd0;
        if (byp && wb_en && wb_addr == a) return wb_data;
        if (byp && wa_en && wa_addr == a) return wa_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [3:0] a, input bit byp);
        if (!m_run || a == 4'd0) return 1'b0;
        if (byp && wr_hit(a)) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            m_known = 1'b1;
            m_run   = 1'b0;
            m_icyc  = 0;
            for (int r = 0; r < 16; r++) m_pend[r] = 1'b0;
        end else if (m_known && !m_run) begin
            // Each INIT cycle clears the next register, x1 first.
            m_mem[m_icyc + 1] = 32'd0;
            m_icyc++;
            if (m_icyc == 15) m_run = 1'b1;
        end else if (m_run) begin
            if (wa_en && wa_addr != 0) m_mem[wa_addr] = wa_data;
            if (wb_en && wb_addr != 0) m_mem[wb_addr] = wb_data;
            if (wa_en) m_pend[wa_addr] = 1'b0;
            if (wb_en) m_pend[wb_addr] = 1'b0;
            if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
        end
    endtask

    task automatic tick();
        exp_t e;
        if (m_known) begin
            for (int p = 0; p < 2; p++) begin
                logic [3:0] a;
                a = rd_addr[p*4 +: 4];
                e.d1[p*32 +: 32] = exp_rd(a, 1'b1);
                e.d0[p*32 +: 32] = exp_rd(a, 1'b0);
                e.b1[p] = exp_busy(a, 1'b1);
                e.b0[p] = exp_busy(a, 1'b0);
            end
            e.done = m_run;
            e.cd = dir_cd; e.cb = dir_cb; e.sel = dir_sel; e.dd = dir_d; e.db = dir_b;
            q.push_back(e);
        end
        dir_cd = 1'b0;
        dir_cb = 1'b0;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wa_en = 1'b0; wb_en = 1'b0; iss_en = 1'b0;
    endtask

    task automatic rand_ops();
        rd_addr  = 8'($urandom);
        wa_en    = 1'($urandom);
        wa_addr  = 4'($urandom);
        wa_data  = $urandom;
        wb_en    = ($urandom_range(0, 2) == 0);
        wb_addr  = 4'($urandom);
        wb_data  = $urandom;
        iss_en   = 1'($urandom);
        iss_addr = 4'($urandom);
    endtask

    task automatic expect_p0(input bit sel, input bit cd, input logic [31:0] d,
                             input bit cb, input logic b);
        dir_sel = sel; dir_cd = cd; dir_d = d; dir_cb = cb; dir_b = b;
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: outputs are combinational, so every cycle with a queued entry is compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("init_done_byp1", 32'(done1), 32'(e.done));
                cmp("init_done_byp0", 32'(done0), 32'(e.done));
                for (int p = 0; p < 2; p++) begin
                    cmp($sformatf("rd_data_byp1[%0d]", p), rd_data1[p*32 +: 32], e.d1[p*32 +: 32]);
                    cmp($sformatf("rd_data_byp0[%0d]", p), rd_data0[p*32 +: 32], e.d0[p*32 +: 32]);
                    cmp($sformatf("rd_busy_byp1[%0d]", p), 32'(rd_busy1[p]), 32'(e.b1[p]));
                    cmp($sformatf("rd_busy_byp0[%0d]", p), 32'(rd_busy0[p]), 32'(e.b0[p]));
                end
                if (e.cd) cmp("directed_data", e.sel ? rd_data1[31:0] : rd_data0[31:0], e.dd);
                if (e.cb) cmp("directed_busy", 32'(e.sel ? rd_busy1[0] : rd_busy0[0]), 32'(e.db));
            end
        end
    end

    initial begin
        for (int r = 0; r < 16; r++) begin
            m_mem[r]  = 32'd0;
            m_pend[r] = 1'b0;
        end
        rd_addr = '0; wa_addr = '0; wb_addr = '0; iss_addr = '0; wa_data = '0; wb_data = '0;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        // Writes and issues during INIT must be ignored.
        for (int i = 0; i < 15; i++) begin
            rand_ops();
            tick();
        end

        // Fill x1..x15, pulse reset, re-init, read back zeros.
        idle();
        for (int r = 1; r < 16; r++) begin
            wa_en = 1'b1; wa_addr = 4'(r); wa_data = $urandom | 32'd1;
            rd_addr = 8'($urandom);
            tick();
        end
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            rd_addr = 8'($urandom);
            tick();
        end
        expect_p0(1'b1, 1'b1, 32'd0, 1'b0, 1'b0);
        for (int r = 1; r < 16; r += 2) begin
            rd_addr = {4'((r + 1) % 16), 4'(r)};
            tick();
        end

        // Same-address dual write: port B wins, forwarded and stored.
        wa_en = 1'b1; wa_addr = 4'd5; wa_data = 32'hDEADBEEF;
        wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h12345678;
        rd_addr = {4'd5, 4'd5};
        expect_p0(1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            expect_p0(1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0);
            tick();
        end

        // x0 ignores writes and issues.
        wa_en = 1'b1; wa_addr = 4'd0; wa_data = 32'hFFFFFFFF;
        iss_en = 1'b1; iss_addr = 4'd0; rd_addr = 8'h00;
        expect_p0(1'b1, 1'b1, 32'd0, 1'b1, 1'b0);
        tick();
        idle();
        expect_p0(1'b1, 1'b1, 32'd0, 1'b1, 1'b0);
        tick();

        // Issue x7, then resolve it with a forwarded write.
        iss_en = 1'b1; iss_addr = 4'd7;
        tick();
        idle();
        rd_addr = {4'd0, 4'd7};
        expect_p0(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
        tick();
        wa_en = 1'b1; wa_addr = 4'd7; wa_data = 32'hA5;
        expect_p0(1'b1, 1'b1, 32'hA5, 1'b1, 1'b0);
        tick();
        idle();
        expect_p0(1'b1, 1'b1, 32'hA5, 1'b1, 1'b0);
        tick();

        // Issue and write of x3 in one cycle: issue wins.
        iss_en = 1'b1; iss_addr = 4'd3;
        wa_en = 1'b1; wa_addr = 4'd3; wa_data = 32'h33;
        tick();
        idle();
        rd_addr = {4'd0, 4'd3};
        expect_p0(1'b1, 1'b1, 32'h33, 1'b1, 1'b1);
        tick();

        // BYPASS=0 instance returns the pre-write value in the write cycle.
        wa_en = 1'b1; wa_addr = 4'd9; wa_data = 32'h11;
        tick();
        wa_data = 32'h55; rd_addr = {4'd0, 4'd9};
        expect_p0(1'b0, 1'b1, 32'h11, 1'b0, 1'b0);
        tick();
        idle();
        expect_p0(1'b0, 1'b1, 32'h55, 1'b0, 1'b0);
        tick();

        for (int i = 0; i < 400; i++) begin
            rand_ops();
            tick();
        end

        // Reset mid-INIT restarts the sweep.
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rd_addr = 8'($urandom);
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            rand_ops();
            tick();
        end

        idle();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
